wshb_arbiter: RTL and testbench

Two-master Wishbone arbiter sharing the single 16-bit SDRAM controller slave port between the VGA frame reader (master 0) and the HPS/mire writer (master 1). Grant is held for a whole Wishbone cycle (`cyc` high). It is re-arbitrated only when the owner releases `cyc`, with alternating priority so neither master starves. It sits between the two `wshb_if` masters and `wb16_sdram16` and runs on the Wishbone clock.

---
 rtl/wshb_arb_pkg.sv | 17 +
 rtl/wshb_if.sv | 29 ++
 rtl/wshb_arbiter_wait_counter.sv | 43 ++++
 rtl/wshb_arbiter.sv | 119 +++++++++++
 tb/tb_wshb_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wshb_arb_pkg.sv
// Shared types and defaults for the two-master Wishbone arbiter.
package wshb_arb_pkg;

  localparam int STARVE_MAX_DEFAULT = 256;

  // Encoding chosen so the state bits double as the one-hot grant vector.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } arb_state_t;

  function automatic logic [1:0] state_grant(input arb_state_t s);
    return logic'(s == GNT1) ? 2'b10 : (s == GNT0) ? 2'b01 : 2'b00;
  endfunction

endpackage

// File: rtl/wshb_if.sv
// Classic Wishbone bus bundle; master drives the request side, slave the return side.
interface wshb_if #(
  parameter int DATA_BYTES = 2
);

  logic                      cyc;
  logic                      stb;
  logic                      we;
  logic [31:0]               adr;
  logic [8*DATA_BYTES-1:0]   dat_ms;
  logic [8*DATA_BYTES-1:0]   dat_sm;
  logic [DATA_BYTES-1:0]     sel;
  logic [2:0]                cti;
  logic [1:0]                bte;
  logic                      ack;
  logic                      err;
  logic                      rty;

  modport master (
    output cyc, stb, we, adr, dat_ms, sel, cti, bte,
    input  dat_sm, ack, err, rty
  );

  modport slave (
    input  cyc, stb, we, adr, dat_ms, sel, cti, bte,
    output dat_sm, ack, err, rty
  );

endinterface

// File: rtl/wshb_arbiter_wait_counter.sv
// Saturating wait counter for one master, with a sticky starve flag.
module wait_counter #(
  parameter int STARVE_MAX = 256,
  parameter int WAIT_W     = $clog2(STARVE_MAX + 1)
) (
  input  logic CLK,
  input  logic NRST,
  input  logic req,
  input  logic granted,
  input  logic starve_clr,
  output logic starve
);

  localparam logic [WAIT_W-1:0] CNT_MAX = WAIT_W'(STARVE_MAX);

  logic              waiting;
  logic [WAIT_W-1:0] count;
  logic [WAIT_W-1:0] count_nxt;

  always_comb begin
    waiting   = req & ~granted;
    count_nxt = '0;
    if (waiting) begin
      count_nxt = (count == CNT_MAX) ? CNT_MAX : count + 1'b1;
    end
  end

  // A new starve event outranks a clear landing on the same edge.
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      count  <= '0;
      starve <= 1'b0;
    end else begin
      count <= count_nxt;
      if (waiting && (count_nxt == CNT_MAX)) begin
        starve <= 1'b1;
      end else if (starve_clr) begin
        starve <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/wshb_arbiter.sv
// Two-master Wishbone arbiter in front of the SDRAM controller port.
// Ownership lasts a whole cyc; ties alternate on the previous owner.
//
// state | meaning
// IDLE  | no owner, slave sees cyc/stb low, fields from master 0
// GNT0  | master 0 (VGA reader) owns the slave port
// GNT1  | master 1 (HPS/mire writer) owns the slave port
module wshb_arbiter
  import wshb_arb_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEFAULT,
  parameter int WAIT_W     = $clog2(STARVE_MAX + 1)
) (
  input  logic        CLK,
  input  logic        NRST,
  wshb_if.slave       wshb_m0,
  wshb_if.slave       wshb_m1,
  wshb_if.master      wshb_s,
  output logic [1:0]  grant,
  output logic [1:0]  starve,
  input  logic        starve_clr
);

  arb_state_t state;
  arb_state_t state_nxt;
  logic       last;
  logic       last_nxt;
  logic       own0;
  logic       own1;

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    case (state)
      IDLE: begin
        if (wshb_m0.cyc && wshb_m1.cyc) begin
          state_nxt = last ? GNT0 : GNT1;
        end else if (wshb_m0.cyc) begin
          state_nxt = GNT0;
        end else if (wshb_m1.cyc) begin
          state_nxt = GNT1;
        end
      end
      GNT0: begin
        if (!wshb_m0.cyc) begin
          last_nxt  = 1'b0;
          state_nxt = wshb_m1.cyc ? GNT1 : IDLE;
        end
      end
      GNT1: begin
        if (!wshb_m1.cyc) begin
          last_nxt  = 1'b1;
          state_nxt = wshb_m0.cyc ? GNT0 : IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign own0  = (state == GNT0);
  assign own1  = (state == GNT1);
  assign grant = state_grant(state);

  // Request path: cyc/stb gated by ownership, the rest muxed (master 0 by default).
  assign wshb_s.cyc    = (own0 & wshb_m0.cyc) | (own1 & wshb_m1.cyc);
  assign wshb_s.stb    = (own0 & wshb_m0.stb) | (own1 & wshb_m1.stb);
  assign wshb_s.we     = own1 ? wshb_m1.we     : wshb_m0.we;
  assign wshb_s.adr    = own1 ? wshb_m1.adr    : wshb_m0.adr;
  assign wshb_s.dat_ms = own1 ? wshb_m1.dat_ms : wshb_m0.dat_ms;
  assign wshb_s.sel    = own1 ? wshb_m1.sel    : wshb_m0.sel;
  assign wshb_s.cti    = own1 ? wshb_m1.cti    : wshb_m0.cti;
  assign wshb_s.bte    = own1 ? wshb_m1.bte    : wshb_m0.bte;

  assign wshb_m0.ack    = wshb_s.ack & own0;
  assign wshb_m0.err    = wshb_s.err & own0;
  assign wshb_m0.rty    = wshb_s.rty & own0;
  assign wshb_m0.dat_sm = wshb_s.dat_sm;
  assign wshb_m1.ack    = wshb_s.ack & own1;
  assign wshb_m1.err    = wshb_s.err & own1;
  assign wshb_m1.rty    = wshb_s.rty & own1;
  assign wshb_m1.dat_sm = wshb_s.dat_sm;

  wait_counter #(
    .STARVE_MAX (STARVE_MAX),
    .WAIT_W     (WAIT_W)
  ) u_wait0 (
    .CLK        (CLK),
    .NRST       (NRST),
    .req        (wshb_m0.cyc),
    .granted    (own0),
    .starve_clr (starve_clr),
    .starve     (starve[0])
  );

  wait_counter #(
    .STARVE_MAX (STARVE_MAX),
    .WAIT_W     (WAIT_W)
  ) u_wait1 (
    .CLK        (CLK),
    .NRST       (NRST),
    .req        (wshb_m1.cyc),
    .granted    (own1),
    .starve_clr (starve_clr),
    .starve     (starve[1])
  );

endmodule

// File: tb/tb_wshb_arbiter.sv
// Self-checking bench for wshb_arbiter: vector table, directed sequences, random vs. model.
module tb_wshb_arbiter;

  localparam int SMAX = 8;

  logic       CLK = 1'b0;
  logic       NRST = 1'b1;
  logic       starve_clr = 1'b0;
  logic [1:0] grant;
  logic [1:0] starve;
  logic       ack_auto = 1'b0;
  logic       ack_drv = 1'b0;

  wshb_if #(.DATA_BYTES(2)) m0_if ();
  wshb_if #(.DATA_BYTES(2)) m1_if ();
  wshb_if #(.DATA_BYTES(2)) s_if ();

  assign s_if.ack = ack_auto ? s_if.stb : ack_drv;

  always #5 CLK = ~CLK;

  wshb_arbiter #(.STARVE_MAX(SMAX)) dut (
    .CLK        (CLK),
    .NRST       (NRST),
    .wshb_m0    (m0_if),
    .wshb_m1    (m1_if),
    .wshb_s     (s_if),
    .grant      (grant),
    .starve     (starve),
    .starve_clr (starve_clr)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: owner index (-1 = nobody), previous owner, waits, flags.
  int         mo_owner;
  int         mo_last;
  int         mo_wcnt [2];
  logic [1:0] mo_starve;

  typedef struct {
    logic       c0;
    logic       c1;
    logic       ack;
    logic [1:0] g;
    logic       scyc;
    logic       a0;
    logic       a1;
  } vec_t;

  vec_t vt [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mo_owner   = -1;
    mo_last    = 1;
    mo_wcnt[0] = 0;
    mo_wcnt[1] = 0;
    mo_starve  = 2'b00;
  endtask

  task automatic model_edge();
    logic c [2];
    int   nown;
    logic waiting;
    c[0] = m0_if.cyc;
    c[1] = m1_if.cyc;
    nown = mo_owner;
    for (int i = 0; i < 2; i++) begin
      waiting = c[i] && (mo_owner != i);
      mo_wcnt[i] = waiting ? ((mo_wcnt[i] < SMAX) ? mo_wcnt[i] + 1 : SMAX) : 0;
      if (waiting && mo_wcnt[i] == SMAX) mo_starve[i] = 1'b1;
      else if (starve_clr) mo_starve[i] = 1'b0;
    end
    if (mo_owner < 0) begin
      if (c[0] && c[1]) nown = 1 - mo_last;
      else if (c[0]) nown = 0;
      else if (c[1]) nown = 1;
    end else if (!c[mo_owner]) begin
      mo_last = mo_owner;
      nown = c[1 - mo_owner] ? 1 - mo_owner : -1;
    end
    mo_owner = nown;
  endtask

  task automatic check_all(input string tag);
    logic [1:0]  eg;
    logic        ecyc, estb, eack;
    logic        from1;
    eg    = (mo_owner == 0) ? 2'b01 : (mo_owner == 1) ? 2'b10 : 2'b00;
    from1 = (mo_owner == 1);
    ecyc  = (mo_owner == 0) ? m0_if.cyc : (mo_owner == 1) ? m1_if.cyc : 1'b0;
    estb  = (mo_owner == 0) ? m0_if.stb : (mo_owner == 1) ? m1_if.stb : 1'b0;
    eack  = ack_auto ? estb : ack_drv;
    chk({tag, ".grant"},  grant, eg);
    chk({tag, ".starve"}, starve, mo_starve);
    chk({tag, ".s_cyc"},  s_if.cyc, ecyc);
    chk({tag, ".s_stb"},  s_if.stb, estb);
    chk({tag, ".s_we"},   s_if.we,     from1 ? m1_if.we     : m0_if.we);
    chk({tag, ".s_adr"},  s_if.adr,    from1 ? m1_if.adr    : m0_if.adr);
    chk({tag, ".s_dat"},  s_if.dat_ms, from1 ? m1_if.dat_ms : m0_if.dat_ms);
    chk({tag, ".s_sel"},  s_if.sel,    from1 ? m1_if.sel    : m0_if.sel);
    chk({tag, ".s_cti"},  s_if.cti,    from1 ? m1_if.cti    : m0_if.cti);
    chk({tag, ".s_bte"},  s_if.bte,    from1 ? m1_if.bte    : m0_if.bte);
    chk({tag, ".m0_ack"}, m0_if.ack, eack && mo_owner == 0);
    chk({tag, ".m1_ack"}, m1_if.ack, eack && mo_owner == 1);
    chk({tag, ".m0_err"}, m0_if.err, s_if.err && mo_owner == 0);
    chk({tag, ".m1_err"}, m1_if.err, s_if.err && mo_owner == 1);
    chk({tag, ".m0_rty"}, m0_if.rty, s_if.rty && mo_owner == 0);
    chk({tag, ".m1_rty"}, m1_if.rty, s_if.rty && mo_owner == 1);
    chk({tag, ".m0_dsm"}, m0_if.dat_sm, s_if.dat_sm);
    chk({tag, ".m1_dsm"}, m1_if.dat_sm, s_if.dat_sm);
  endtask

  task automatic tick();
    model_edge();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_m(input int i, input logic cyc, input logic stb, input logic we,
                       input logic [31:0] adr, input logic [15:0] dat, input logic [1:0] sel,
                       input logic [2:0] cti, input logic [1:0] bte);
    if (i == 0) begin
      m0_if.cyc = cyc; m0_if.stb = stb; m0_if.we = we; m0_if.adr = adr;
      m0_if.dat_ms = dat; m0_if.sel = sel; m0_if.cti = cti; m0_if.bte = bte;
    end else begin
      m1_if.cyc = cyc; m1_if.stb = stb; m1_if.we = we; m1_if.adr = adr;
      m1_if.dat_ms = dat; m1_if.sel = sel; m1_if.cti = cti; m1_if.bte = bte;
    end
  endtask

  task automatic set_simple(input int i, input logic cyc, input logic we,
                            input logic [31:0] adr, input logic [15:0] dat);
    set_m(i, cyc, cyc, we, adr, dat, 2'b11, 3'b000, 2'b00);
  endtask

  task automatic do_reset();
    NRST = 1'b0;
    model_reset();
    set_simple(0, 1'b0, 1'b0, 32'h0, 16'h0);
    set_simple(1, 1'b0, 1'b0, 32'h0, 16'h0);
    ack_auto = 1'b0;
    ack_drv = 1'b0;
    starve_clr = 1'b0;
    s_if.err = 1'b0;
    s_if.rty = 1'b0;
    s_if.dat_sm = 16'h0;
    repeat (2) @(posedge CLK);
    #1;
    NRST = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int prev;
    int who;
    logic a0, a1;

    vt[0]  = '{1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
    vt[1]  = '{1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0};
    vt[2]  = '{1'b1, 1'b1, 1'b1, 2'b01, 1'b1, 1'b1, 1'b0};
    vt[3]  = '{1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0};
    vt[4]  = '{1'b1, 1'b1, 1'b1, 2'b10, 1'b1, 1'b0, 1'b1};
    vt[5]  = '{1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0};
    vt[6]  = '{1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0};
    vt[7]  = '{1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
    vt[8]  = '{1'b1, 1'b1, 1'b1, 2'b10, 1'b1, 1'b0, 1'b1};
    vt[9]  = '{1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0};
    vt[10] = '{1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0};
    vt[11] = '{1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};

    #2;
    do_reset();
    #1;
    check_all("reset");

    // Vector table: tie after reset, handovers, tie after m0 was last owner.
    for (int i = 0; i < 12; i++) begin
      set_simple(0, vt[i].c0, 1'b0, 32'h10 + i, 16'h1000 + 16'(i));
      set_simple(1, vt[i].c1, 1'b1, 32'h20 + i, 16'h2000 + 16'(i));
      ack_drv = vt[i].ack;
      #1;
      chk($sformatf("vec%0d.grant", i), grant, vt[i].g);
      chk($sformatf("vec%0d.s_cyc", i), s_if.cyc, vt[i].scyc);
      chk($sformatf("vec%0d.m0_ack", i), m0_if.ack, vt[i].a0);
      chk($sformatf("vec%0d.m1_ack", i), m1_if.ack, vt[i].a1);
      tick();
    end

    // m1 alone writes 0xBEEF to 0x100.
    do_reset();
    set_simple(1, 1'b1, 1'b1, 32'h100, 16'hBEEF);
    #1;
    check_all("wr.pre");
    tick();
    chk("wr.grant", grant, 2'b10);
    chk("wr.adr", s_if.adr, 32'h100);
    chk("wr.dat", s_if.dat_ms, 16'hBEEF);
    chk("wr.we", s_if.we, 1'b1);
    ack_drv = 1'b1;
    #1;
    chk("wr.m1_ack", m1_if.ack, 1'b1);
    chk("wr.m0_ack", m0_if.ack, 1'b0);
    check_all("wr.ack");
    ack_drv = 1'b0;
    set_simple(1, 1'b0, 1'b0, 32'h0, 16'h0);
    tick();
    check_all("wr.rel");
    tick();

    // m0 4-beat burst while m1 waits.
    set_simple(0, 1'b1, 1'b0, 32'h200, 16'h0);
    set_simple(1, 1'b1, 1'b1, 32'h300, 16'h3333);
    tick();
    for (int b = 0; b < 4; b++) begin
      set_simple(0, 1'b1, 1'b0, 32'h200 + b, 16'h0);
      ack_drv = 1'b1;
      #1;
      chk($sformatf("burst%0d.m1_ack", b), m1_if.ack, 1'b0);
      chk($sformatf("burst%0d.adr", b), s_if.adr, 32'h200 + b);
      check_all("burst");
      tick();
    end
    ack_drv = 1'b0;
    set_simple(0, 1'b0, 1'b0, 32'h0, 16'h0);
    #1;
    check_all("burst.drop");
    tick();
    chk("burst.handover_grant", grant, 2'b10);
    chk("burst.handover_adr", s_if.adr, 32'h300);
    check_all("burst.m1");
    set_simple(1, 1'b0, 1'b0, 32'h0, 16'h0);
    tick();
    tick();

    // Starvation of m1 behind a long m0 cycle, then clear.
    do_reset();
    set_simple(0, 1'b1, 1'b0, 32'h400, 16'h0);
    tick();
    set_simple(1, 1'b1, 1'b1, 32'h500, 16'h5555);
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk($sformatf("starve.wait%0d", k), {31'b0, starve[1]}, (k >= SMAX) ? 32'd1 : 32'd0);
      check_all("starve");
    end
    set_simple(0, 1'b0, 1'b0, 32'h0, 16'h0);
    tick();
    chk("starve.grant", grant, 2'b10);
    chk("starve.sticky", starve, 2'b10);
    starve_clr = 1'b1;
    tick();
    starve_clr = 1'b0;
    #1;
    chk("starve.cleared", starve, 2'b00);
    check_all("starve.clr");

    // Asynchronous reset in the middle of m1's burst.
    ack_drv = 1'b1;
    tick();
    check_all("rst.pre");
    #2;
    NRST = 1'b0;
    model_reset();
    #1;
    chk("rst.grant", grant, 2'b00);
    chk("rst.s_cyc", s_if.cyc, 1'b0);
    chk("rst.s_stb", s_if.stb, 1'b0);
    ack_drv = 1'b0;
    set_simple(0, 1'b1, 1'b0, 32'h600, 16'h0);
    @(posedge CLK);
    #1;
    NRST = 1'b1;
    #1;
    check_all("rst.rel");
    tick();
    chk("rst.tie_m0", grant, 2'b01);
    check_all("rst.after");

    // Back-to-back single cycles from both masters must alternate.
    do_reset();
    ack_auto = 1'b1;
    set_simple(0, 1'b1, 1'b0, 32'h700, 16'h0);
    set_simple(1, 1'b1, 1'b1, 32'h800, 16'h8888);
    prev = -1;
    for (int n = 0; n < 30; n++) begin
      #1;
      a0 = m0_if.ack;
      a1 = m1_if.ack;
      check_all("alt");
      if (a0 || a1) begin
        who = a1 ? 1 : 0;
        chk("alt.order", who, (prev < 0) ? 0 : 1 - prev);
        prev = who;
      end
      set_simple(0, !a0, 1'b0, 32'h700 + n, 16'h0);
      set_simple(1, !a1, 1'b1, 32'h800 + n, 16'h8800 + 16'(n));
      tick();
    end
    ack_auto = 1'b0;

    // Randomized traffic against the model.
    do_reset();
    for (int n = 0; n < 500; n++) begin
      logic c0n, c1n;
      c0n = m0_if.cyc ? ($urandom_range(0, 99) < 85) : ($urandom_range(0, 99) < 35);
      c1n = m1_if.cyc ? ($urandom_range(0, 99) < 85) : ($urandom_range(0, 99) < 35);
      set_m(0, c0n, c0n & 1'($urandom), 1'($urandom), $urandom, 16'($urandom),
            2'($urandom), 3'($urandom), 2'($urandom));
      set_m(1, c1n, c1n & 1'($urandom), 1'($urandom), $urandom, 16'($urandom),
            2'($urandom), 3'($urandom), 2'($urandom));
      ack_drv = 1'($urandom);
      s_if.err = ($urandom_range(0, 7) == 0);
      s_if.rty = ($urandom_range(0, 7) == 0);
      s_if.dat_sm = 16'($urandom);
      starve_clr = ($urandom_range(0, 15) == 0);
      #1;
      if ($urandom_range(0, 99) == 0) begin
        NRST = 1'b0;
        model_reset();
        #1;
        check_all("rnd.rst");
        @(posedge CLK);
        #1;
        NRST = 1'b1;
      end else begin
        check_all("rnd");
        tick();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
